// File: rtl/map_scroll_ctrl.sv
// Camera scroll controller: converts four level direction requests into
// per-axis scroll offsets that update once per frame on the leading vsync
// edge. Each axis ramps its speed up over several frames while the request
// is held, coasts down when released, and wraps toroidally at the map edges.

// One scroll axis: position register, speed ramp and its motion FSM.
// The position advances by the speed held before the update (old speed), so
// the first frame after a request moves zero pixels.
module map_scroll_axis #(
  parameter int MAP       = 320,
  parameter int PW        = 9,
  parameter int MAX_SPEED = 4,
  parameter int ACCEL_DIV = 4,
  parameter int SW        = 3,
  parameter int CW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          req_pos_i,
  input  logic          req_neg_i,
  output logic [PW-1:0] pos_o,
  output logic [SW-1:0] speed_o,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    AX_IDLE   = 2'd0,
    AX_ACCEL  = 2'd1,
    AX_CRUISE = 2'd2,
    AX_DECEL  = 2'd3
  } axis_state_e;

  localparam logic [PW:0]   MAP_EXT  = (PW+1)'(MAP);
  localparam logic [SW-1:0] SPD_MAX  = SW'(MAX_SPEED);
  localparam logic [SW-1:0] SPD_ONE  = SW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_DIV - 1);

  axis_state_e   state_q, state_d;
  logic [SW-1:0] speed_q, speed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;   // 1: positive direction, 0: negative
  logic [PW-1:0] pos_q, pos_d;

  logic          req_valid;
  logic          same_dir;
  logic [SW-1:0] speed_inc;
  logic [SW-1:0] speed_dec;
  logic [PW:0]   pos_ext;
  logic [PW:0]   spd_ext;
  logic [PW:0]   pos_sum;
  logic [PW:0]   pos_next;

  // Request decode: exactly one of the pair gives a direction, both/neither is no request.
  assign req_valid = req_pos_i ^ req_neg_i;
  assign same_dir  = req_valid && (req_pos_i == dir_q);
  assign speed_inc = speed_q + SPD_ONE;
  assign speed_dec = speed_q - SPD_ONE;

  // Wrapped position step using the old speed, computed one bit wider than the position.
  always_comb begin
    pos_ext  = {1'b0, pos_q};
    spd_ext  = (PW+1)'(speed_q);
    pos_sum  = pos_ext + spd_ext;
    pos_next = pos_ext;
    if (dir_q) begin
      pos_next = (pos_sum >= MAP_EXT) ? (pos_sum - MAP_EXT) : pos_sum;
    end else begin
      pos_next = (pos_ext < spd_ext) ? (pos_ext + MAP_EXT - spd_ext)
                                     : (pos_ext - spd_ext);
    end
  end

  // Next-state logic: everything holds unless this is an unpaused frame tick.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    if (en_i) begin
      pos_d = PW'(pos_next);
      case (state_q)
        AX_IDLE: begin
          if (req_valid) begin
            state_d = (SPD_ONE == SPD_MAX) ? AX_CRUISE : AX_ACCEL;
            dir_d   = req_pos_i;
            speed_d = SPD_ONE;
            cnt_d   = '0;
          end
        end
        AX_ACCEL: begin
          if (same_dir) begin
            if (cnt_q == CNT_LAST) begin
              speed_d = speed_inc;
              cnt_d   = '0;
              if (speed_inc == SPD_MAX) state_d = AX_CRUISE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            speed_d = speed_dec;
            state_d = (speed_q == SPD_ONE) ? AX_IDLE : AX_DECEL;
          end
        end
        AX_CRUISE: begin
          if (!same_dir) begin
            speed_d = speed_dec;
            state_d = (speed_q == SPD_ONE) ? AX_IDLE : AX_DECEL;
          end
        end
        AX_DECEL: begin
          if (same_dir) begin
            state_d = AX_ACCEL;
            cnt_d   = '0;
          end else begin
            speed_d = speed_dec;
            state_d = (speed_q == SPD_ONE) ? AX_IDLE : AX_DECEL;
          end
        end
        default: begin
          state_d = AX_IDLE;
          speed_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Axis state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AX_IDLE;
      speed_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
    end
  end

  assign pos_o   = pos_q;
  assign speed_o = speed_q;
  assign state_o = state_q;

endmodule

// Top level: frame tick generation from vsync plus two independent axes.
module map_scroll_ctrl #(
  parameter int   MAP_W     = 320,
  parameter int   MAP_H     = 240,
  parameter int   XW        = 9,
  parameter int   YW        = 8,
  parameter int   MAX_SPEED = 4,
  parameter int   ACCEL_DIV = 4,
  parameter logic VSYNC_ACT = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               vsync,
  input  logic                               pause,
  input  logic                               mv_up,
  input  logic                               mv_down,
  input  logic                               mv_left,
  input  logic                               mv_right,
  output logic [XW-1:0]                      scroll_x,
  output logic [YW-1:0]                      scroll_y,
  output logic                               frame_tick,
  output logic                               moving,
  output logic [1:0]                         dbg_state_x_o,
  output logic [1:0]                         dbg_state_y_o,
  output logic [$clog2(MAX_SPEED+1)-1:0]     dbg_speed_x_o,
  output logic [$clog2(MAX_SPEED+1)-1:0]     dbg_speed_y_o
);

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int CW = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;

  logic          vs_q;
  logic          armed_q;       // set once vsync has been seen inactive after reset
  logic          frame_tick_q;
  logic          tick;
  logic          axis_en;
  logic [SW-1:0] speed_x;
  logic [SW-1:0] speed_y;

  // Leading edge of vsync; armed_q blocks a tick when reset is released mid-pulse.
  assign tick    = armed_q && (vsync == VSYNC_ACT) && (vs_q != VSYNC_ACT);
  assign axis_en = tick && !pause;

  // vsync history, arming flag and the registered frame tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q         <= ~VSYNC_ACT;
      armed_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_q         <= vsync;
      armed_q      <= armed_q | (vsync != VSYNC_ACT);
      frame_tick_q <= tick;
    end
  end

  map_scroll_axis #(
    .MAP(MAP_W), .PW(XW), .MAX_SPEED(MAX_SPEED), .ACCEL_DIV(ACCEL_DIV),
    .SW(SW), .CW(CW)
  ) u_axis_x (
    .clk       (clk),
    .rst       (rst),
    .en_i      (axis_en),
    .req_pos_i (mv_right),
    .req_neg_i (mv_left),
    .pos_o     (scroll_x),
    .speed_o   (speed_x),
    .state_o   (dbg_state_x_o)
  );

  map_scroll_axis #(
    .MAP(MAP_H), .PW(YW), .MAX_SPEED(MAX_SPEED), .ACCEL_DIV(ACCEL_DIV),
    .SW(SW), .CW(CW)
  ) u_axis_y (
    .clk       (clk),
    .rst       (rst),
    .en_i      (axis_en),
    .req_pos_i (mv_down),
    .req_neg_i (mv_up),
    .pos_o     (scroll_y),
    .speed_o   (speed_y),
    .state_o   (dbg_state_y_o)
  );

  // Speeds only change on the tick edge, so this is stable between frames.
  assign moving        = (speed_x != '0) || (speed_y != '0);
  assign frame_tick    = frame_tick_q;
  assign dbg_speed_x_o = speed_x;
  assign dbg_speed_y_o = speed_y;

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Bench for map_scroll_ctrl: reset behaviour, a table of per-frame vectors,
// hand-written wrap/reversal sequences and a randomized run against a model.
module tb_map_scroll_ctrl;

  localparam int   MAP_W     = 320;
  localparam int   MAP_H     = 240;
  localparam int   XW        = 9;
  localparam int   YW        = 8;
  localparam int   MAX_SPEED = 4;
  localparam int   ACCEL_DIV = 4;
  localparam logic VS_ACT    = 1'b0;
  localparam int   SW        = $clog2(MAX_SPEED + 1);
  localparam int   W         = XW + YW + SW + SW + 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [SW-1:0] sx;
    logic [SW-1:0] sy;
    logic          mv;
  } exp_t;

  typedef struct {
    logic up, down, left, right, pz;
    int   x, y, sx, sy;
    logic mv;
  } vec_t;

  logic          clk, rst, vsync, pause;
  logic          mv_up, mv_down, mv_left, mv_right;
  logic [XW-1:0] scroll_x;
  logic [YW-1:0] scroll_y;
  logic          frame_tick, moving;
  logic [1:0]    dbg_state_x_o, dbg_state_y_o;
  logic [SW-1:0] dbg_speed_x_o, dbg_speed_y_o;

  logic [W-1:0]  exp_q[$];
  vec_t          tbl[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  // reference model state
  int mpx, mpy, msx, msy, mcx, mcy, mdx, mdy;
  bit max_acc, may_acc;

  int ramp_pos[13] = '{0, 1, 2, 3, 4, 6, 8, 10, 12, 15, 18, 21, 24};
  int ramp_spd[13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4};

  map_scroll_ctrl #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .XW(XW), .YW(YW),
    .MAX_SPEED(MAX_SPEED), .ACCEL_DIV(ACCEL_DIV), .VSYNC_ACT(VS_ACT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vsync         (vsync),
    .pause         (pause),
    .mv_up         (mv_up),
    .mv_down       (mv_down),
    .mv_left       (mv_left),
    .mv_right      (mv_right),
    .scroll_x      (scroll_x),
    .scroll_y      (scroll_y),
    .frame_tick    (frame_tick),
    .moving        (moving),
    .dbg_state_x_o (dbg_state_x_o),
    .dbg_state_y_o (dbg_state_y_o),
    .dbg_speed_x_o (dbg_speed_x_o),
    .dbg_speed_y_o (dbg_speed_y_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit hit before finish");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  function automatic logic [W-1:0] pack_exp(input int x, input int y,
                                            input int sx, input int sy, input bit mv);
    exp_t e;
    e.x  = XW'(x);
    e.y  = YW'(y);
    e.sx = SW'(sx);
    e.sy = SW'(sy);
    e.mv = mv;
    return W'(e);
  endfunction

  task automatic add_row(input logic u, input logic d, input logic l, input logic r,
                         input logic p, input int x, input int y, input int sx,
                         input int sy, input logic mv);
    vec_t v;
    v.up = u; v.down = d; v.left = l; v.right = r; v.pz = p;
    v.x = x; v.y = y; v.sx = sx; v.sy = sy; v.mv = mv;
    tbl.push_back(v);
  endtask

  // driver: sets requests, produces one vsync pulse and scores the frame
  task automatic apply_tick(input string tag, input logic u, input logic d,
                            input logic l, input logic r, input logic p);
    int   seen;
    exp_t ee;
    seen = 0;
    @(negedge clk);
    mv_up = u; mv_down = d; mv_left = l; mv_right = r; pause = p;
    vsync = VS_ACT;
    repeat (3) begin
      @(negedge clk);
      if (frame_tick) seen++;
    end
    vsync = ~VS_ACT;
    repeat (3) begin
      @(negedge clk);
      if (frame_tick) seen++;
    end
    check({tag, ".tick_pulses"}, seen, 1);
    check({tag, ".queued"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      ee = exp_t'(exp_q.pop_front());
      check({tag, ".scroll_x"}, int'(scroll_x), int'(ee.x));
      check({tag, ".scroll_y"}, int'(scroll_y), int'(ee.y));
      check({tag, ".speed_x"}, int'(dbg_speed_x_o), int'(ee.sx));
      check({tag, ".speed_y"}, int'(dbg_speed_y_o), int'(ee.sy));
      check({tag, ".moving"}, int'(moving), int'(ee.mv));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; vsync = ~VS_ACT; pause = 1'b0;
    mv_up = 1'b0; mv_down = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Behavioural model of one axis: speed ramps 1 per ACCEL_DIV held frames,
  // drops 1 per frame otherwise; position moves by the pre-update speed.
  task automatic model_axis(input int map, input bit rp, input bit rn, input bit pz,
                            inout int pos, inout int spd, inout int cnt,
                            inout int dir, inout bit acc);
    int req;
    if (pz) return;
    req = (rp && !rn) ? 1 : ((rn && !rp) ? -1 : 0);
    pos = ((pos + dir * spd) % map + map) % map;
    if (spd == 0) begin
      if (req != 0) begin
        dir = req; spd = 1; cnt = 0; acc = 1'b1;
      end
    end else if (req == dir) begin
      if (!acc) begin
        acc = 1'b1; cnt = 0;
      end else if (spd < MAX_SPEED) begin
        cnt++;
        if (cnt == ACCEL_DIV) begin
          spd++; cnt = 0;
        end
      end
    end else begin
      spd--; acc = 1'b0;
    end
  endtask

  // 0 stopped, 1 speeding up, 2 at top speed, 3 slowing down
  function automatic int model_phase(input int spd, input bit acc);
    if (spd == 0) return 0;
    if (acc && spd == MAX_SPEED) return 2;
    if (acc) return 1;
    return 3;
  endfunction

  initial begin
    int seen;
    logic [3:0] cur;
    logic pz;

    rst = 1'b0; vsync = ~VS_ACT; pause = 1'b0;
    mv_up = 1'b0; mv_down = 1'b0; mv_left = 1'b0; mv_right = 1'b0;

    // reset held with a request and a toggling vsync
    repeat (2) @(negedge clk);
    mv_right = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vsync = ~vsync;
      if (frame_tick) seen++;
    end
    check("rst.tick_count", seen, 0);
    check("rst.scroll_x", int'(scroll_x), 0);
    check("rst.scroll_y", int'(scroll_y), 0);
    check("rst.moving", int'(moving), 0);

    // release while vsync is already active: no tick until a fresh edge
    vsync = VS_ACT;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (frame_tick) seen++;
    end
    check("rel_active.tick_count", seen, 0);
    check("rel_active.scroll_x", int'(scroll_x), 0);
    vsync = ~VS_ACT;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pack_exp(ramp_pos[i], 0, ramp_spd[i], 0, 1'b1));
      apply_tick("rel_ramp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    // reset mid-acceleration clears everything immediately
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.scroll_x", int'(scroll_x), 0);
    check("midrst.speed_x", int'(dbg_speed_x_o), 0);
    check("midrst.state_x", int'(dbg_state_x_o), 0);
    check("midrst.moving", int'(moving), 0);

    // table of frames: ramp, pause, coast, conflict, restart left
    add_row(0,0,0,1,0,  0,0,1,0,1);
    add_row(0,0,0,1,0,  1,0,1,0,1);
    add_row(0,0,0,1,0,  2,0,1,0,1);
    add_row(0,0,0,1,0,  3,0,1,0,1);
    add_row(0,0,0,1,0,  4,0,2,0,1);
    add_row(0,0,0,1,0,  6,0,2,0,1);
    add_row(0,0,0,1,0,  8,0,2,0,1);
    add_row(0,0,0,1,0, 10,0,2,0,1);
    add_row(0,0,0,1,0, 12,0,3,0,1);
    add_row(0,0,0,1,0, 15,0,3,0,1);
    add_row(0,0,0,1,0, 18,0,3,0,1);
    add_row(0,0,0,1,0, 21,0,3,0,1);
    add_row(0,0,0,1,0, 24,0,4,0,1);
    add_row(0,0,0,1,1, 24,0,4,0,1);
    add_row(0,0,0,1,1, 24,0,4,0,1);
    add_row(0,0,0,1,0, 28,0,4,0,1);
    add_row(0,0,0,0,0, 32,0,3,0,1);
    add_row(0,0,0,0,0, 35,0,2,0,1);
    add_row(0,0,0,0,0, 37,0,1,0,1);
    add_row(0,0,0,0,0, 38,0,0,0,0);
    add_row(0,0,0,0,0, 38,0,0,0,0);
    add_row(1,1,0,0,0, 38,0,0,0,0);
    add_row(1,1,0,0,0, 38,0,0,0,0);
    add_row(0,0,1,0,0, 38,0,1,0,1);
    add_row(0,0,1,0,0, 37,0,1,0,1);
    add_row(0,0,1,0,0, 36,0,1,0,1);
    do_reset();
    foreach (tbl[i]) begin
      exp_q.push_back(pack_exp(tbl[i].x, tbl[i].y, tbl[i].sx, tbl[i].sy, tbl[i].mv));
      apply_tick($sformatf("tbl%0d", i), tbl[i].up, tbl[i].down, tbl[i].left,
                 tbl[i].right, tbl[i].pz);
    end

    // left from 0 wraps to MAP_W-1
    do_reset();
    exp_q.push_back(pack_exp(0, 0, 1, 0, 1'b1));
    apply_tick("wrapx1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pack_exp(319, 0, 1, 0, 1'b1));
    apply_tick("wrapx2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pack_exp(318, 0, 1, 0, 1'b1));
    apply_tick("wrapx3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // hold down long enough to cross MAP_H at full speed
    do_reset();
    for (int n = 1; n <= 68; n++) begin
      if (n <= 13) exp_q.push_back(pack_exp(0, ramp_pos[n-1], 0, ramp_spd[n-1], 1'b1));
      else         exp_q.push_back(pack_exp(0, (24 + 4 * (n - 13)) % MAP_H, 0, 4, 1'b1));
      apply_tick($sformatf("wrapy%0d", n), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // reversal from cruise right to left goes through a stop
    do_reset();
    for (int n = 0; n < 13; n++) begin
      exp_q.push_back(pack_exp(ramp_pos[n], 0, ramp_spd[n], 0, 1'b1));
      apply_tick("rev_ramp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    exp_q.push_back(pack_exp(28, 0, 3, 0, 1'b1)); apply_tick("rev1", 0, 0, 1, 0, 0);
    exp_q.push_back(pack_exp(31, 0, 2, 0, 1'b1)); apply_tick("rev2", 0, 0, 1, 0, 0);
    exp_q.push_back(pack_exp(33, 0, 1, 0, 1'b1)); apply_tick("rev3", 0, 0, 1, 0, 0);
    exp_q.push_back(pack_exp(34, 0, 0, 0, 1'b0)); apply_tick("rev4", 0, 0, 1, 0, 0);
    check("rev4.state_x", int'(dbg_state_x_o), 0);
    exp_q.push_back(pack_exp(34, 0, 1, 0, 1'b1)); apply_tick("rev5", 0, 0, 1, 0, 0);
    exp_q.push_back(pack_exp(33, 0, 1, 0, 1'b1)); apply_tick("rev6", 0, 0, 1, 0, 0);
    exp_q.push_back(pack_exp(32, 0, 1, 0, 1'b1)); apply_tick("rev7", 0, 0, 1, 0, 0);

    // randomized frames against the behavioural model
    do_reset();
    mpx = 0; mpy = 0; msx = 0; msy = 0; mcx = 0; mcy = 0; mdx = 1; mdy = 1;
    max_acc = 1'b0; may_acc = 1'b0;
    cur = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) cur = 4'($urandom_range(0, 15));
      pz = ($urandom_range(0, 9) == 0);
      model_axis(MAP_W, cur[0], cur[1], pz, mpx, msx, mcx, mdx, max_acc);
      model_axis(MAP_H, cur[2], cur[3], pz, mpy, msy, mcy, mdy, may_acc);
      exp_q.push_back(pack_exp(mpx, mpy, msx, msy, (msx != 0) || (msy != 0)));
      apply_tick($sformatf("rnd%0d", n), cur[3], cur[2], cur[1], cur[0], pz);
      check($sformatf("rnd%0d.state_x", n), int'(dbg_state_x_o), model_phase(msx, max_acc));
      check($sformatf("rnd%0d.state_y", n), int'(dbg_state_y_o), model_phase(msy, may_acc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
